// File: rtl/mux_pkg.sv
// Shared constants for the round-robin stream mux: mode encoding and FSM state type.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority encoder: returns the first requester at or after ptr,
// wrapping past N_IN-1 back to 0.
module rr_arbiter #(
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  // Walk from the farthest candidate back to ptr so the nearest requester wins last.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N_IN]) begin
        gnt_idx = SEL_W'((int'(ptr) + k) % N_IN);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with fixed or round-robin channel choice, packet
// locking until in_last, and a single registered output stage.
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic [N_IN-1:0]         in_valid,
  input  logic [N_IN-1:0]         in_last,
  output logic [N_IN-1:0]         in_ready,
  output logic [WIDTH-1:0]        o_data,
  output logic [SEL_W-1:0]        o_ch,
  output logic                    o_last,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic                    fsm_state
);

  // Handshake: a beat moves on a channel or the output only on a clock edge where its
  // valid and ready are both high; the output register holds while o_valid & !o_ready.

  state_t             state;
  logic [SEL_W-1:0]   rr_ptr;
  logic [SEL_W-1:0]   lock_ch;
  logic [SEL_W-1:0]   gnt;
  logic [SEL_W-1:0]   arb_idx;
  logic [SEL_W-1:0]   next_ptr;
  logic               arb_any;
  logic               gnt_bit;
  logic               grant_valid;
  logic               can_load;
  logic               xfer;
  logic               sel_last;
  logic [WIDTH-1:0]   sel_data;

  rr_arbiter #(.N_IN(N_IN)) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  always_comb begin
    gnt = lock_ch;
    if (state == ST_IDLE) gnt = (mode == MODE_RR) ? arb_idx : sel;
  end

  // An out-of-range gnt (sel >= N_IN) matches no channel, so it never grants.
  always_comb begin
    gnt_bit  = 1'b0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (gnt == SEL_W'(i)) begin
        gnt_bit  = in_valid[i];
        sel_data = in_data[i*WIDTH +: WIDTH];
        sel_last = in_last[i];
      end
    end
  end

  assign grant_valid = (state == ST_IDLE && mode == MODE_RR) ? arb_any : gnt_bit;
  assign can_load    = !o_valid || o_ready;
  assign xfer        = can_load && grant_valid;
  assign next_ptr    = (gnt == SEL_W'(N_IN - 1)) ? '0 : gnt + SEL_W'(1);
  assign fsm_state   = state;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_IN; i++) begin
      in_ready[i] = can_load && grant_valid && (gnt == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      lock_ch <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ch    <= '0;
      o_last  <= 1'b0;
    end else begin
      if (can_load) begin
        o_valid <= xfer;
        if (xfer) begin
          o_data <= sel_data;
          o_ch   <= gnt;
          o_last <= sel_last;
        end
      end
      if (xfer) begin
        if (sel_last) begin
          state  <= ST_IDLE;
          rr_ptr <= next_ptr;
        end else begin
          state   <= ST_LOCKED;
          lock_ch <= gnt;
        end
      end
    end
  end

endmodule
